// File: rtl/booth_mult.sv
// booth_mult: sequential radix-2 Booth signed multiplier, one step per clock
module booth_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mult_in,
  output logic             busy,
  output logic             mult_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d, m_q, m_d, sum, sh_acc;
  logic [WIDTH-1:0] q_q, q_d, sh_q, hi_q, hi_d, lo_q, lo_d;
  logic             q1_q, q1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  assign busy     = state_q != IDLE;
  assign mult_out = state_q == DONE;
  assign hi       = hi_q;
  assign lo       = lo_q;
  // Booth step datapath and FSM next-state; add/sub at WIDTH+1 bits so negating the most negative M cannot overflow
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum     = ({q_q[0], q1_q} == 2'b10) ? acc_q - m_q :
              ({q_q[0], q1_q} == 2'b01) ? acc_q + m_q : acc_q;
    sh_acc  = {sum[WIDTH], sum[WIDTH:1]};
    sh_q    = {sum[0], q_q[WIDTH-1:1]};
    case (state_q)
      IDLE: if (mult_in) begin
        m_d     = {A[WIDTH-1], A};
        q_d     = B;
        acc_d   = '0;
        q1_d    = 1'b0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        acc_d = sh_acc;
        q_d   = sh_q;
        q1_d  = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          hi_d    = sh_acc[WIDTH-1:0];
          lo_d    = sh_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule

// File: tb/tb_booth_mult.sv
// tb_booth_mult: directed self-checking bench for booth_mult
module tb_booth_mult;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic        mult_in = 1'b0;
  logic        busy, mult_out;
  logic [31:0] hi, lo;
  int          cmp = 0, err = 0;
  logic [31:0] last_hi = '0, last_lo = '0;

  booth_mult #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .A(A), .B(B), .mult_in(mult_in),
    .busy(busy), .mult_out(mult_out), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input string tag, input int poke);
    int n;
    A = a; B = b; mult_in = 1'b1;
    tick();
    mult_in = 1'b0;
    A = ~a; B = a ^ b;
    chk({tag, " busy_after_start"}, busy, 1'b1);
    n = 0;
    do begin
      tick();
      n++;
      if (n == poke) begin
        mult_in = 1'b1; A = 32'd2; B = 32'd2;
      end else mult_in = 1'b0;
      if (n == 10) chk({tag, " hilo_hold_mid_run"}, {hi, lo}, {last_hi, last_lo});
    end while (!mult_out && n < 40);
    chk({tag, " latency"}, n, 32);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    chk({tag, " busy_at_done"}, busy, 1'b1);
    last_hi = eh; last_lo = el;
    tick();
    chk({tag, " idle_after_done"}, {busy, mult_out}, 2'b00);
    chk({tag, " hilo_hold_idle"}, {hi, lo}, {eh, el});
  endtask

  initial begin
    int pulses, bad, unst;
    logic exp_pulse;
    tick(); tick();
    chk("reset_outputs", {busy, mult_out, hi, lo}, 66'd0);
    reset = 1'b0;
    tick();
    chk("idle_hold", {busy, mult_out}, 2'b00);

    run_mult(32'd6, 32'd7, 32'h0, 32'h2A, "6x7", 0);
    run_mult(32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "m3x5", 0);
    run_mult(32'd5, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF1, "5xm3", 0);
    run_mult(32'h80000000, 32'h80000000, 32'h40000000, 32'h0, "minxmin", 0);
    run_mult(32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000, "minx1", 0);
    run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, "m1xm1", 0);
    run_mult(32'd0, 32'h12345678, 32'h0, 32'h0, "0xk", 0);
    run_mult(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, "maxxmax", 0);
    run_mult(32'd6, 32'd7, 32'h0, 32'h2A, "6x7_poke", 10);

    A = 32'd100; B = 32'd100; mult_in = 1'b1;
    tick();
    mult_in = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("rst_mid_hold", {hi, lo}, {32'h0, 32'h2A});
    reset = 1'b1;
    tick();
    chk("rst_mid_clear", {busy, mult_out, hi, lo}, 66'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mult_out) pulses++;
    end
    chk("rst_no_pulse", pulses, 0);
    last_hi = '0; last_lo = '0;
    run_mult(32'd3, 32'd4, 32'h0, 32'd12, "3x4", 0);

    A = 32'd2; B = 32'd9; mult_in = 1'b1;
    tick();
    pulses = 0; bad = 0; unst = 0;
    for (int e = 1; e <= 104; e++) begin
      tick();
      exp_pulse = (e % 34) == 32;
      if (mult_out !== exp_pulse) bad++;
      if (mult_out) pulses++;
      if ({hi, lo} !== ((e < 32) ? {32'h0, 32'd12} : {32'h0, 32'd18})) unst++;
    end
    mult_in = 1'b0;
    chk("cont_pulse_positions", bad, 0);
    chk("cont_pulse_count", pulses, 3);
    chk("cont_hilo_stable", unst, 0);
    for (int i = 0; i < 40 && busy; i++) tick();
    chk("cont_returns_idle", {busy, lo}, {1'b0, 32'd18});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
